// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Streams a program into instruction memory, then releases the CPU
//            from reset for a fixed window. Optional checksum word: BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK = 3'd2,
`endif
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [15:0]     C_RUN_LAST = 16'(RUN_CYCLES - 1);
`ifdef BOOT_CHECKSUM_EN
    localparam state_t          C_LOAD_EXIT = ST_CHECK;
`else
    localparam state_t          C_LOAD_EXIT = ST_RUN;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_index;
    logic [ADDR_W:0]     w_index_inc;
    logic [15:0]         r_run_cnt;
    logic                w_xfer;
    logic                w_start_ok;
    logic                r_s_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [DATA_W-1:0]   r_imem_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   w_sum_total;

    assign w_sum_total = r_sum + s_data;
`endif

    assign w_xfer      = s_valid & r_s_ready;
    assign w_index_inc = r_index + C_ONE;
    assign w_start_ok  = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERROR));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_start_ok) begin
                    if (prog_len > C_DEPTH)
                        w_state_nxt = ST_ERROR;
                    else if (prog_len == '0)
                        w_state_nxt = C_LOAD_EXIT;
                    else
                        w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && (w_index_inc == r_len))
                    w_state_nxt = C_LOAD_EXIT;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (w_xfer)
                    w_state_nxt = (w_sum_total == '0) ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN: begin
                if (r_run_cnt == C_RUN_LAST)
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_index      <= '0;
            r_run_cnt    <= '0;
            r_s_ready    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
`ifdef BOOT_CHECKSUM_EN
            r_s_ready   <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK);
            r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK) ||
                           (w_state_nxt == ST_RUN);
`else
            r_s_ready   <= (w_state_nxt == ST_LOAD);
            r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
`endif
            r_done      <= (w_state_nxt == ST_DONE);
            r_error     <= (w_state_nxt == ST_ERROR);
            r_cpu_reset <= (w_state_nxt != ST_RUN);
            r_imem_we   <= 1'b0;

            if (w_start_ok) begin
                r_len   <= prog_len;
                r_index <= '0;
`ifdef BOOT_CHECKSUM_EN
                r_sum   <= '0;
`endif
            end

            if ((r_state == ST_LOAD) && w_xfer) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_index[ADDR_W-1:0];
                r_imem_wdata <= s_data;
                r_index      <= w_index_inc;
`ifdef BOOT_CHECKSUM_EN
                r_sum        <= w_sum_total;
`endif
            end

            if (r_state == ST_RUN)
                r_run_cnt <= r_run_cnt + 16'd1;
            else
                r_run_cnt <= '0;
        end
    end

    assign s_ready    = r_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// Directed self-checking bench for imem_boot_loader (default parameters).
module tb_imem_boot_loader;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int RUN_CYCLES = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    imem_boot_loader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_len   (prog_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run_cycles = 0;
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    logic [7:0] prog [0:9];

    always @(posedge clk) cyc <= cyc + 1;

    // Write and CPU-release monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(int'(imem_wdata));
            wr_cyc_q.push_back(cyc);
        end
        if (cpu_reset === 1'b0)
            run_cycles <= run_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        prog_len = (ADDR_W+1)'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d, input int gap);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_timeout", 32'(guard < 50), 32'd1);
        tick();
        s_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_range(input int lo, input int hi, input int mode);
        for (int i = lo; i <= hi; i++) begin
            if (mode == 1)
                push_word(prog[i], (i == 2) ? 5 : 1);
            else
                push_word(prog[i], 0);
        end
    endtask

    task automatic send_checksum_ok();
`ifdef BOOT_CHECKSUM_EN
        push_word(8'h1C, 0);
`endif
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("end_timeout", 32'(n < bound), 32'd1);
    endtask

    task automatic verify_writes(input string tag, input int base);
        check({tag, "_count"}, 32'(wr_addr_q.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < wr_addr_q.size()) begin
                check({tag, "_addr"}, 32'(wr_addr_q[base+i]), 32'(i));
                check({tag, "_data"}, 32'(wr_data_q[base+i]), {24'd0, prog[i]});
            end
        end
    endtask

    initial begin
        int b0;
        int rc0;
        prog[0] = 8'hC0; prog[1] = 8'h05; prog[2] = 8'hC1; prog[3] = 8'h09;
        prog[4] = 8'h30; prog[5] = 8'h91; prog[6] = 8'h78; prog[7] = 8'h14;
        prog[8] = 8'h08; prog[9] = 8'h00;

        reset = 1'b1; start = 1'b0; prog_len = '0; s_valid = 1'b0; s_data = '0;
        tick();
        tick();
        check("rst_s_ready",    32'(s_ready),    32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        reset = 1'b0;
        tick();

        // Program streamed with s_valid held high
        b0 = wr_addr_q.size(); rc0 = run_cycles;
        do_start(10);
        check("t1_busy",    32'(busy),      32'd1);
        check("t1_s_ready", 32'(s_ready),   32'd1);
        check("t1_cpu_rst", 32'(cpu_reset), 32'd1);
        send_range(0, 9, 0);
        send_checksum_ok();
        wait_end(200);
        check("t1_done",     32'(done),      32'd1);
        check("t1_error",    32'(error),     32'd0);
        check("t1_busy_end", 32'(busy),      32'd0);
        check("t1_cpu_end",  32'(cpu_reset), 32'd1);
        check("t1_run_len",  32'(run_cycles - rc0), 32'(RUN_CYCLES));
        verify_writes("t1", b0);
        for (int i = 1; i < 10; i++) begin
            if (b0 + i < wr_cyc_q.size())
                check("t1_back_to_back", 32'(wr_cyc_q[b0+i] - wr_cyc_q[b0+i-1]), 32'd1);
        end

        // Toggled s_valid with a long gap; start from DONE clears done
        b0 = wr_addr_q.size(); rc0 = run_cycles;
        do_start(10);
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_busy",         32'(busy), 32'd1);
        send_range(0, 9, 1);
        send_checksum_ok();
        wait_end(200);
        check("t2_done",    32'(done), 32'd1);
        check("t2_run_len", 32'(run_cycles - rc0), 32'(RUN_CYCLES));
        verify_writes("t2", b0);

        // Oversized program is rejected with no writes
        b0 = wr_addr_q.size(); rc0 = run_cycles;
        do_start(257);
        check("t3_error",   32'(error),     32'd1);
        check("t3_busy",    32'(busy),      32'd0);
        check("t3_done",    32'(done),      32'd0);
        check("t3_cpu_rst", 32'(cpu_reset), 32'd1);
        check("t3_s_ready", 32'(s_ready),   32'd0);
        repeat (5) tick();
        check("t3_no_write", 32'(wr_addr_q.size() - b0), 32'd0);
        check("t3_no_run",   32'(run_cycles - rc0),      32'd0);

        // Empty program
        rc0 = run_cycles;
        do_start(0);
`ifdef BOOT_CHECKSUM_EN
        check("t4_check_ready", 32'(s_ready), 32'd1);
        push_word(8'h00, 0);
`else
        check("t4_cpu_rst_low", 32'(cpu_reset), 32'd0);
        check("t4_busy",        32'(busy),      32'd1);
        check("t4_error_clr",   32'(error),     32'd0);
`endif
        wait_end(200);
        check("t4_done",    32'(done), 32'd1);
        check("t4_run_len", 32'(run_cycles - rc0), 32'(RUN_CYCLES));

        // start pulses during LOAD and RUN are ignored
        b0 = wr_addr_q.size(); rc0 = run_cycles;
        do_start(10);
        send_range(0, 1, 0);
        do_start(3);
        send_range(2, 9, 0);
        send_checksum_ok();
        repeat (5) tick();
        check("t5_in_run", 32'(cpu_reset), 32'd0);
        do_start(5);
        wait_end(200);
        check("t5_done",    32'(done), 32'd1);
        check("t5_run_len", 32'(run_cycles - rc0), 32'(RUN_CYCLES));
        verify_writes("t5", b0);

        // Reset in the middle of a load, with a word offered on the reset edge
        b0 = wr_addr_q.size();
        do_start(10);
        send_range(0, 3, 0);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        tick();
        check("t6_imem_we",  32'(imem_we),   32'd0);
        check("t6_s_ready",  32'(s_ready),   32'd0);
        check("t6_cpu_rst",  32'(cpu_reset), 32'd1);
        check("t6_busy",     32'(busy),      32'd0);
        check("t6_done",     32'(done),      32'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        repeat (4) tick();
        check("t6_writes",     32'(wr_addr_q.size() - b0), 32'd4);
        check("t6_still_idle", 32'(busy), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum word leads to ERROR with nothing extra written
        b0 = wr_addr_q.size(); rc0 = run_cycles;
        do_start(10);
        send_range(0, 9, 0);
        push_word(8'h1D, 0);
        wait_end(200);
        check("t7_error",   32'(error),     32'd1);
        check("t7_done",    32'(done),      32'd0);
        check("t7_cpu_rst", 32'(cpu_reset), 32'd1);
        check("t7_no_run",  32'(run_cycles - rc0), 32'd0);
        verify_writes("t7", b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
